// File: rtl/arith_unit_mc.sv
// Handshaked arithmetic unit: single-cycle add/sub/shift/rotate plus an
// iterative shift-add multiplier and restoring divider sharing one datapath.
module arith_unit_mc #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         carry,
  output logic         zero,
  output logic         div_zero
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // the producer holds its payload stable until that edge.
  localparam int CW = $clog2(N) + 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ROTL = 3'b110;
  localparam logic [2:0] OP_ROTR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [N-1:0]  m_q, m_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  result_q, result_d;
  logic [N-1:0]  result_hi_q, result_hi_d;
  logic          carry_q, carry_d;
  logic          zero_q, zero_d;
  logic          div_zero_q, div_zero_d;

  logic [N:0]    add_w, sub_w, mul_sum, div_shift, div_diff;
  logic [N-1:0]  hi_n, lo_n;

  assign add_w     = {1'b0, a} + {1'b0, b};
  assign sub_w     = {1'b0, a} - {1'b0, b};
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
  assign div_shift = {hi_q, lo_q[N-1]};
  assign div_diff  = div_shift - {1'b0, m_q};

  // One iteration: mul shifts {carry,hi,lo} right after a conditional add;
  // div shifts the dividend into the remainder and keeps it if no borrow.
  always_comb begin
    hi_n = hi_q;
    lo_n = lo_q;
    if (op_q == OP_MUL) begin
      hi_n = mul_sum[N:1];
      lo_n = {mul_sum[0], lo_q[N-1:1]};
    end else if (!div_diff[N]) begin
      hi_n = div_diff[N-1:0];
      lo_n = {lo_q[N-2:0], 1'b1};
    end else begin
      hi_n = div_shift[N-1:0];
      lo_n = {lo_q[N-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    m_d         = m_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    div_zero_d  = div_zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d        = op;
          cnt_d       = '0;
          state_d     = DONE;
          result_hi_d = '0;
          carry_d     = 1'b0;
          div_zero_d  = 1'b0;
          case (op)
            OP_ADD: begin
              result_d = add_w[N-1:0];
              carry_d  = add_w[N];
            end
            OP_SUB: begin
              result_d = sub_w[N-1:0];
              carry_d  = sub_w[N];
            end
            OP_MUL: begin
              state_d = BUSY;
              m_d     = a;
              hi_d    = '0;
              lo_d    = b;
            end
            OP_DIV: begin
              if (b == '0) begin
                result_d    = '1;
                result_hi_d = a;
                div_zero_d  = 1'b1;
              end else begin
                state_d = BUSY;
                m_d     = b;
                hi_d    = '0;
                lo_d    = a;
              end
            end
            OP_SHL: begin
              result_d = {a[N-2:0], 1'b0};
              carry_d  = a[N-1];
            end
            OP_SHR: begin
              result_d = {1'b0, a[N-1:1]};
              carry_d  = a[0];
            end
            OP_ROTL: result_d = {a[N-2:0], a[N-1]};
            OP_ROTR: result_d = {a[0], a[N-1:1]};
            default: result_d = '0;
          endcase
          if (state_d == DONE) zero_d = (result_d == '0);
        end
      end
      BUSY: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d     = DONE;
          result_d    = lo_n;
          result_hi_d = hi_n;
          div_zero_d  = 1'b0;
          if (op_q == OP_MUL) begin
            carry_d = |hi_n;
            zero_d  = (lo_n == '0) && (hi_n == '0);
          end else begin
            carry_d = 1'b0;
            zero_d  = (lo_n == '0);
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      m_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      m_q         <= m_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_arith_unit_mc.sv
// Bench for arith_unit_mc: directed cases then randomized operations, each
// result compared with an arithmetic reference model via an expected queue.
module tb_arith_unit_mc;
  localparam int N = 8;
  localparam longint M = 64'd1 << N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a_i = '0;
  logic [N-1:0] b_i = '0;
  logic [2:0]   op_i = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] result;
  logic [N-1:0] result_hi;
  logic         carry;
  logic         zero;
  logic         div_zero;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [N-1:0] res;
    logic [N-1:0] hi;
    logic         c;
    logic         z;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t exp_q[$];

  arith_unit_mc #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .op        (op_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .zero      (zero),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model from plain integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    longint ai, bi, s, p;
    ai = longint'(a);
    bi = longint'(b);
    e.hi = '0; e.c = 1'b0; e.dz = 1'b0; e.lat = 1;
    e.res = '0;
    case (op)
      3'd0: begin s = ai + bi; e.res = N'(s % M); e.c = (s >= M); end
      3'd1: begin e.res = N'((ai - bi + M) % M); e.c = (ai < bi); end
      3'd2: begin
        p = ai * bi;
        e.res = N'(p % M); e.hi = N'(p / M); e.c = (p / M) != 0; e.lat = N + 1;
      end
      3'd3: begin
        if (bi == 0) begin
          e.res = N'(M - 1); e.hi = a; e.dz = 1'b1;
        end else begin
          e.res = N'(ai / bi); e.hi = N'(ai % bi); e.lat = N + 1;
        end
      end
      3'd4: begin e.res = N'((ai * 2) % M); e.c = (ai >= M / 2); end
      3'd5: begin e.res = N'(ai / 2); e.c = (ai % 2) == 1; end
      3'd6: e.res = N'((ai * 2) % M + ai / (M / 2));
      default: e.res = N'(ai / 2 + (ai % 2) * (M / 2));
    endcase
    if (op == 3'd2) e.z = (ai * bi == 0);
    else e.z = (e.res == '0);
    return e;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b, input int bp);
    exp_t e;
    int lat;
    logic rdy_seen, stable;
    logic [N-1:0] r0, h0;
    logic [2:0] f0;
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op_i = 3'($urandom); a_i = N'($urandom); b_i = N'($urandom);
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 50) begin
      rdy_seen |= in_ready;
      @(posedge clk); #1;
      lat++;
    end
    e = exp_q.pop_front();
    if (!out_valid) begin
      chk("timeout", 32'(out_valid), 32'd1);
      return;
    end
    rdy_seen |= in_ready;
    chk("latency", 32'(lat), 32'(e.lat));
    chk("in_ready_busy", 32'(rdy_seen), 32'd0);
    chk("result", 32'(result), 32'(e.res));
    chk("result_hi", 32'(result_hi), 32'(e.hi));
    chk("carry", 32'(carry), 32'(e.c));
    chk("zero", 32'(zero), 32'(e.z));
    chk("div_zero", 32'(div_zero), 32'(e.dz));
    if (bp > 0) begin
      r0 = result; h0 = result_hi; f0 = {carry, zero, div_zero};
      stable = 1'b1;
      repeat (bp) begin
        in_valid = 1'($urandom); op_i = 3'($urandom); a_i = N'($urandom); b_i = N'($urandom);
        @(posedge clk); #1;
        if (!out_valid || in_ready || result !== r0 || result_hi !== h0 ||
            {carry, zero, div_zero} !== f0) stable = 1'b0;
      end
      in_valid = 1'b0;
      chk("hold_stable", 32'(stable), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [2:0] rop;
    logic [N-1:0] ra, rb;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outputs", 32'({result, result_hi, carry, zero, div_zero}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 8'hF0, 8'h20, 0);
    run_op(3'd1, 8'h05, 8'h07, 0);
    run_op(3'd1, 8'h07, 8'h07, 0);
    run_op(3'd2, 8'hFF, 8'hFF, 0);
    run_op(3'd3, 8'd200, 8'd7, 0);
    run_op(3'd3, 8'd9, 8'd0, 0);
    run_op(3'd0, 8'h12, 8'h34, 5);
    run_op(3'd4, 8'h81, 8'h00, 0);
    run_op(3'd5, 8'h81, 8'h00, 0);
    run_op(3'd6, 8'h81, 8'h00, 0);
    run_op(3'd7, 8'h81, 8'h00, 0);

    // Abort a multiply partway through BUSY with an asynchronous reset.
    run_op(3'd2, 8'h0F, 8'h11, 0);
    @(negedge clk);
    in_valid = 1'b1; op_i = 3'd2; a_i = 8'hAB; b_i = 8'hCD;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_outputs", 32'({result, result_hi, carry, zero, div_zero}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 8'h01, 8'h02, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = N'($urandom);
      rb = N'($urandom);
      if (rop == 3'd2 && rb == '0) rb = 8'd1;
      if (rop == 3'd3 && $urandom_range(0, 7) == 0) rb = '0;
      run_op(rop, ra, rb, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
